// File: rtl/pe_mac_sat_if.sv
// rtl/pe_mac_sat_if.sv - operand, forwarding and partial-sum signals of one systolic PE
// master drives operands into a PE; slave is the PE side.
interface pe_mac_sat_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid_i;
  logic                  clear_i;
  logic [DATA_WIDTH-1:0] srca_i;
  logic [DATA_WIDTH-1:0] srcb_i;
  logic                  valid_o;
  logic                  clear_o;
  logic [DATA_WIDTH-1:0] srca_o;
  logic [DATA_WIDTH-1:0] srcb_o;
  logic [DATA_WIDTH-1:0] psum_o;
  logic                  psum_valid_o;
  logic                  ovf_o;

  modport master (
    output valid_i, clear_i, srca_i, srcb_i,
    input  valid_o, clear_o, srca_o, srcb_o, psum_o, psum_valid_o, ovf_o
  );

  modport slave (
    input  valid_i, clear_i, srca_i, srcb_i,
    output valid_o, clear_o, srca_o, srcb_o, psum_o, psum_valid_o, ovf_o
  );
endinterface

// File: rtl/pe_mac_sat.sv
// rtl/pe_mac_sat.sv - systolic PE: signed fixed-point MAC with guard bits, rounding, saturation
// Two-stage pipeline: product register, then accumulator; psum is scaled combinationally from acc.
module pe_mac_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int SATURATE   = 1,
  parameter int ROUND      = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  pe_mac_sat_if.slave  bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int HW = ACC_WIDTH - DATA_WIDTH + 2;

  localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]        PSUM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]        PSUM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]    HALF     =
    (ROUND != 0) ? ((ACC_WIDTH+1)'(1) << (FRAC_BITS-1)) : '0;

  // Scale an accumulator value down to psum precision, one guard bit wide so the rounding add cannot wrap.
  function automatic logic signed [ACC_WIDTH:0] f_scale(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH:0] w_r;
    w_r = (ACC_WIDTH+1)'(acc) + HALF;
    return w_r >>> FRAC_BITS;
  endfunction

  function automatic logic f_out_of_range(input logic signed [ACC_WIDTH:0] s);
    logic [HW-1:0] w_hi;
    w_hi = s[ACC_WIDTH:DATA_WIDTH-1];
    return !((&w_hi) || !(|w_hi));
  endfunction

  logic [DATA_WIDTH-1:0]        r_srca;
  logic [DATA_WIDTH-1:0]        r_srcb;
  logic                         r_valid;
  logic                         r_clear;
  logic signed [PW-1:0]         r_p;
  logic                         r_pv;
  logic                         r_pc;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_ovf;
  logic                         r_psum_valid;

  logic signed [DATA_WIDTH-1:0] w_a;
  logic signed [DATA_WIDTH-1:0] w_b;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_p_ext;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_acc_ovf;
  logic signed [ACC_WIDTH-1:0]  w_sum_fit;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic                         w_ovf_next;
  logic signed [ACC_WIDTH:0]    w_s_next;
  logic                         w_next_oor;
  logic signed [ACC_WIDTH:0]    w_s;
  logic                         w_psum_oor;
  logic [DATA_WIDTH-1:0]        w_psum;

  assign w_a    = bus.srca_i;
  assign w_b    = bus.srcb_i;
  // The true product always fits in PW bits, so the low half of a PW x PW multiply is exact.
  assign w_prod = PW'(w_a) * PW'(w_b);

  assign w_p_ext   = ACC_WIDTH'(r_p);
  assign w_sum     = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_p_ext);
  assign w_acc_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    w_sum_fit = w_sum[ACC_WIDTH-1:0];
    if (w_acc_ovf && (SATURATE != 0)) begin
      w_sum_fit = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    w_ovf_next = r_ovf;
    if (r_pc) begin
      w_acc_next = r_pv ? w_p_ext : '0;
      w_ovf_next = 1'b0;
    end else if (r_pv) begin
      w_acc_next = w_sum_fit;
      w_ovf_next = r_ovf | w_acc_ovf;
    end
  end

  // The psum range check looks at the value acc is about to take, so ovf_o rises with it.
  assign w_s_next   = f_scale(w_acc_next);
  assign w_next_oor = f_out_of_range(w_s_next);

  assign w_s        = f_scale(r_acc);
  assign w_psum_oor = f_out_of_range(w_s);

  always_comb begin
    w_psum = w_s[DATA_WIDTH-1:0];
    if (w_psum_oor && (SATURATE != 0)) begin
      w_psum = w_s[ACC_WIDTH] ? PSUM_MIN : PSUM_MAX;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_srca       <= '0;
      r_srcb       <= '0;
      r_valid      <= 1'b0;
      r_clear      <= 1'b0;
      r_p          <= '0;
      r_pv         <= 1'b0;
      r_pc         <= 1'b0;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_psum_valid <= 1'b0;
    end else begin
      r_srca       <= bus.srca_i;
      r_srcb       <= bus.srcb_i;
      r_valid      <= bus.valid_i;
      r_clear      <= bus.clear_i;
      r_p          <= w_prod;
      r_pv         <= bus.valid_i;
      r_pc         <= bus.clear_i;
      r_acc        <= w_acc_next;
      r_ovf        <= w_ovf_next | (r_pv & w_next_oor);
      r_psum_valid <= r_pv;
    end
  end

  assign bus.srca_o       = r_srca;
  assign bus.srcb_o       = r_srcb;
  assign bus.valid_o      = r_valid;
  assign bus.clear_o      = r_clear;
  assign bus.psum_o       = w_psum;
  assign bus.psum_valid_o = r_psum_valid;
  assign bus.ovf_o        = r_ovf;

endmodule

// File: tb/tb_pe_mac_sat.sv
// tb/tb_pe_mac_sat.sv - bench for pe_mac_sat: default, ROUND=0 and SATURATE=0 instances
// All three PEs see the same stimulus and are compared against an arithmetic reference model.
module tb_pe_mac_sat;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pe_mac_sat_if #(.DATA_WIDTH(16)) ifd ();
  pe_mac_sat_if #(.DATA_WIDTH(16)) ifr ();
  pe_mac_sat_if #(.DATA_WIDTH(16)) ifs ();

  pe_mac_sat #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .SATURATE(1), .ROUND(1))
    u_dut_d (.clk_i(clk), .rst_i(rst), .bus(ifd));
  pe_mac_sat #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .SATURATE(1), .ROUND(0))
    u_dut_r (.clk_i(clk), .rst_i(rst), .bus(ifr));
  pe_mac_sat #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .SATURATE(0), .ROUND(1))
    u_dut_s (.clk_i(clk), .rst_i(rst), .bus(ifs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          c;
    logic [15:0] a;
    logic [15:0] b;
    longint      p;
  } op_t;

  localparam longint AMAX = (longint'(1) <<< 39) - 1;
  localparam longint AMIN = -(longint'(1) <<< 39);

  op_t    q[$];
  op_t    m_fwd;
  longint m_acc [3];
  bit     m_ovf [3];
  bit     m_pv;
  int     cyc;

  function automatic longint scale(longint acc, bit rnd);
    return (acc + (rnd ? 128 : 0)) >>> 8;
  endfunction

  function automatic bit oor(longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [15:0] psum_of(longint acc, bit rnd, bit sat);
    longint s;
    s = scale(acc, rnd);
    if (sat && s > 32767)  s = 32767;
    if (sat && s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic longint wrap40(longint x);
    longint w;
    w = x & ((longint'(1) <<< 40) - 1);
    if (w > AMAX) w = w - (longint'(1) <<< 40);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input int k, input op_t cur);
    bit     rnd;
    bit     sat;
    longint sum;
    rnd = (k != 1);
    sat = (k != 2);
    if (cur.c) begin
      m_acc[k] = cur.v ? cur.p : 0;
      m_ovf[k] = 1'b0;
    end else if (cur.v) begin
      sum = m_acc[k] + cur.p;
      if (sum > AMAX || sum < AMIN) begin
        m_ovf[k] = 1'b1;
        if (sat) sum = (sum > AMAX) ? AMAX : AMIN;
        else     sum = wrap40(sum);
      end
      m_acc[k] = sum;
    end
    if (cur.v && oor(scale(m_acc[k], rnd))) m_ovf[k] = 1'b1;
  endtask

  task automatic check_all();
    chk($sformatf("d.psum@%0d", cyc), 32'(ifd.psum_o), 32'(psum_of(m_acc[0], 1, 1)));
    chk($sformatf("r.psum@%0d", cyc), 32'(ifr.psum_o), 32'(psum_of(m_acc[1], 0, 1)));
    chk($sformatf("s.psum@%0d", cyc), 32'(ifs.psum_o), 32'(psum_of(m_acc[2], 1, 0)));
    chk($sformatf("d.ovf@%0d", cyc), 32'(ifd.ovf_o), 32'(m_ovf[0]));
    chk($sformatf("r.ovf@%0d", cyc), 32'(ifr.ovf_o), 32'(m_ovf[1]));
    chk($sformatf("s.ovf@%0d", cyc), 32'(ifs.ovf_o), 32'(m_ovf[2]));
    chk($sformatf("d.psum_valid@%0d", cyc), 32'(ifd.psum_valid_o), 32'(m_pv));
    chk($sformatf("d.fwd@%0d", cyc),
        {ifd.valid_o, ifd.clear_o, ifd.srca_o[13:0], ifd.srcb_o},
        {m_fwd.v, m_fwd.c, m_fwd.a[13:0], m_fwd.b});
    chk($sformatf("d.srca_hi@%0d", cyc), 32'(ifd.srca_o[15:14]), 32'(m_fwd.a[15:14]));
  endtask

  task automatic step(input bit r, input bit v, input bit c, input logic [15:0] a, input logic [15:0] b);
    op_t op;
    op_t cur;
    rst = r;
    ifd.valid_i = v; ifd.clear_i = c; ifd.srca_i = a; ifd.srcb_i = b;
    ifr.valid_i = v; ifr.clear_i = c; ifr.srca_i = a; ifr.srcb_i = b;
    ifs.valid_i = v; ifs.clear_i = c; ifs.srca_i = a; ifs.srcb_i = b;
    @(posedge clk);
    #1;
    cyc++;
    m_pv = 1'b0;
    if (r) begin
      q.delete();
      for (int k = 0; k < 3; k++) begin
        m_acc[k] = 0;
        m_ovf[k] = 1'b0;
      end
      m_fwd = '{v: 1'b0, c: 1'b0, a: 16'h0, b: 16'h0, p: 0};
    end else begin
      op = '{v: v, c: c, a: a, b: b, p: longint'($signed(a)) * longint'($signed(b))};
      q.push_back(op);
      m_fwd = op;
      if (q.size() > 1) begin
        cur = q.pop_front();
        m_pv = cur.v;
        for (int k = 0; k < 3; k++) apply(k, cur);
      end
    end
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst = 1'b1;

    step(1, 0, 0, 16'h0, 16'h0);
    step(1, 0, 0, 16'h0, 16'h0);
    chk("reset.psum", 32'(ifd.psum_o), 32'h0);
    chk("reset.ovf", 32'(ifd.ovf_o), 32'h0);
    chk("reset.valid_o", 32'(ifd.valid_o), 32'h0);
    chk("reset.psum_valid", 32'(ifd.psum_valid_o), 32'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);

    step(0, 1, 1, 16'h0180, 16'h0200);
    chk("mac.srca_fwd", 32'(ifd.srca_o), 32'h0180);
    step(0, 1, 0, 16'h0180, 16'h0200);
    chk("mac.psum1", 32'(ifd.psum_o), 32'h0300);
    step(0, 1, 0, 16'h0180, 16'h0200);
    chk("mac.psum2", 32'(ifd.psum_o), 32'h0600);
    step(0, 1, 0, 16'h0180, 16'h0200);
    chk("mac.psum3", 32'(ifd.psum_o), 32'h0900);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("mac.psum4", 32'(ifd.psum_o), 32'h0C00);
    chk("mac.psum_valid4", 32'(ifd.psum_valid_o), 32'h1);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("mac.psum_valid_end", 32'(ifd.psum_valid_o), 32'h0);

    step(0, 1, 1, 16'h0001, 16'h0080);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("round.up", 32'(ifd.psum_o), 32'h0001);
    chk("trunc.pos", 32'(ifr.psum_o), 32'h0000);
    step(0, 1, 1, 16'hFFFF, 16'h0080);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("round.neg", 32'(ifd.psum_o), 32'h0000);
    chk("trunc.neg", 32'(ifr.psum_o), 32'hFFFF);

    step(0, 1, 1, 16'h7F00, 16'h7F00);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("sat.psum", 32'(ifd.psum_o), 32'h7FFF);
    chk("sat.ovf", 32'(ifd.ovf_o), 32'h1);
    chk("wrap.ovf", 32'(ifs.ovf_o), 32'h1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 16'h0);
    chk("ovf.sticky", 32'(ifd.ovf_o), 32'h1);
    step(0, 0, 1, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("clear.psum", 32'(ifd.psum_o), 32'h0);
    chk("clear.ovf", 32'(ifd.ovf_o), 32'h0);

    step(0, 1, 1, 16'h0100, 16'h0100);
    step(0, 0, 0, 16'h0100, 16'h0100);
    chk("bubble.first", 32'(ifd.psum_o), 32'h0100);
    step(0, 1, 0, 16'h0100, 16'h0100);
    chk("bubble.hold", 32'(ifd.psum_o), 32'h0100);
    step(0, 0, 0, 16'h0100, 16'h0100);
    chk("bubble.second", 32'(ifd.psum_o), 32'h0200);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("bubble.hold2", 32'(ifd.psum_o), 32'h0200);

    step(0, 1, 1, 16'h0300, 16'h0100);
    step(1, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);
    chk("rst.discard", 32'(ifd.psum_o), 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = 16'($signed(12'($urandom)));
        b = 16'($signed(10'($urandom)));
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), a, b);
    end

    step(0, 1, 1, 16'h8000, 16'h8000);
    for (int i = 0; i < 560; i++) step(0, 1, 0, 16'h8000, 16'h8000);
    step(0, 1, 1, 16'h8000, 16'h7FFF);
    for (int i = 0; i < 560; i++) step(0, 1, 0, 16'h8000, 16'h7FFF);
    step(0, 0, 0, 16'h0, 16'h0);
    step(0, 0, 0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
